// File: rtl/sm_addsub_pipe.sv
// Three-stage sign-magnitude add/sub/accumulate pipeline with a valid/ready stream
// interface, a saturating two's-complement accumulator and a per-result clamp flag.
module sm_addsub_pipe #(
    parameter int WIDTH = 18,
    parameter int ACC_W = 24
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_p,
    input  logic [WIDTH-1:0]   in_q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_res,
    output logic               out_ovf,
    output logic [1:0]         out_op
);

    localparam int N  = ACC_W + 1;
    localparam int M  = ACC_W;
    localparam int LV = $clog2(M);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [N-1:0] ONE_N      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] MAXMAG_TC  = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic [N-1:0] NEGMAX_TC  = ~MAXMAG_TC + ONE_N;

    function automatic logic [N-1:0] neg_tc(input logic [N-1:0] v);
        return ~v + ONE_N;
    endfunction

    // Negating a zero magnitude yields zero, so -0 folds to 0 here.
    function automatic logic [N-1:0] sm_to_tc(input logic [WIDTH-1:0] sm);
        logic [N-1:0] mag;
        mag = {{(N-WIDTH+1){1'b0}}, sm[WIDTH-2:0]};
        if (sm[WIDTH-1]) begin
            return neg_tc(mag);
        end else begin
            return mag;
        end
    endfunction

    // Returns {ovf, clamped value}.
    function automatic logic [N:0] clamp_tc(input logic [N-1:0] v);
        if ($signed(v) > $signed(MAXMAG_TC)) begin
            return {1'b1, MAXMAG_TC};
        end else if ($signed(v) < $signed(NEGMAX_TC)) begin
            return {1'b1, NEGMAX_TC};
        end else begin
            return {1'b0, v};
        end
    endfunction

    function automatic logic [ACC_W-1:0] tc_to_sm(input logic [N-1:0] v);
        logic [N-1:0] mag;
        if (v[N-1]) begin
            mag = neg_tc(v);
        end else begin
            mag = v;
        end
        return {v[N-1], mag[ACC_W-2:0]};
    endfunction

    logic             w_en;
    logic             r_s1_valid;
    logic [1:0]       r_s1_op;
    logic [N-1:0]     r_s1_p;
    logic [N-1:0]     r_s1_q;
    logic             r_s2_valid;
    logic [1:0]       r_s2_op;
    logic [N-1:0]     r_s2_sum;
    logic [N-1:0]     r_acc;
    logic             r_out_valid;
    logic [1:0]       r_out_op;
    logic [ACC_W-1:0] r_out_res;
    logic             r_out_ovf;

    logic [N-1:0]     w_s2_b;
    logic [N-1:0]     w_s2_half;
    logic [N-1:0]     w_s2_sum;
    logic [N:0]       w_s2_clamp;
    logic [N:0]       w_s3_clamp;
    logic [M-1:0]     w_pg_g [0:LV];
    logic [M-1:0]     w_pg_p [0:LV-1];

    assign w_en      = !(r_out_valid && !out_ready);
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign out_op    = r_out_op;
    assign out_res   = r_out_res;
    assign out_ovf   = r_out_ovf;

    // Stage 1: capture the beat and convert both operands to two's complement.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_p     <= '0;
            r_s1_q     <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_op    <= in_op;
            r_s1_p     <= sm_to_tc(in_p);
            if (in_op == OP_SUB) begin
                r_s1_q <= neg_tc(sm_to_tc(in_q));
            end else begin
                r_s1_q <= sm_to_tc(in_q);
            end
        end
    end

    // Second adder input depends on the opcode.
    always_comb begin
        w_s2_b = '0;
        case (r_s1_op)
            OP_ADD:  w_s2_b = r_s1_q;
            OP_SUB:  w_s2_b = r_s1_q;
            OP_ACC:  w_s2_b = r_acc;
            OP_LOAD: w_s2_b = '0;
            default: w_s2_b = '0;
        endcase
    end

    // Kogge-Stone carry network over the low M bits; the top sum bit only needs carry M-1.
    always_comb begin
        w_s2_half = r_s1_p ^ w_s2_b;
        w_pg_g[0] = r_s1_p[M-1:0] & w_s2_b[M-1:0];
        w_pg_p[0] = w_s2_half[M-1:0];
        for (int l = 0; l < LV - 1; l++) begin
            for (int i = 0; i < M; i++) begin
                if (i >= (32'sd1 <<< l)) begin
                    w_pg_p[l+1][i] = w_pg_p[l][i] & w_pg_p[l][i - (32'sd1 <<< l)];
                end else begin
                    w_pg_p[l+1][i] = w_pg_p[l][i];
                end
            end
        end
        for (int l = 0; l < LV; l++) begin
            for (int i = 0; i < M; i++) begin
                if (i >= (32'sd1 <<< l)) begin
                    w_pg_g[l+1][i] = w_pg_g[l][i]
                                   | (w_pg_p[l][i] & w_pg_g[l][i - (32'sd1 <<< l)]);
                end else begin
                    w_pg_g[l+1][i] = w_pg_g[l][i];
                end
            end
        end
        w_s2_sum   = w_s2_half ^ {w_pg_g[LV], 1'b0};
        w_s2_clamp = clamp_tc(w_s2_sum);
    end

    // Stage 2: register the raw sum; ACC/LOAD commit the clamped sum to the accumulator.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_s2_valid <= 1'b0;
            r_s2_op    <= OP_ADD;
            r_s2_sum   <= '0;
            r_acc      <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_op    <= r_s1_op;
            r_s2_sum   <= w_s2_sum;
            if (r_s1_valid && r_s1_op[1]) begin
                r_acc <= w_s2_clamp[N-1:0];
            end
        end
    end

    assign w_s3_clamp = clamp_tc(r_s2_sum);

    // Stage 3: clamp, flag and convert back to sign-magnitude into the output registers.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_op    <= OP_ADD;
            r_out_res   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_op  <= r_s2_op;
                r_out_res <= tc_to_sm(w_s3_clamp[N-1:0]);
                r_out_ovf <= w_s3_clamp[N];
            end
        end
    end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Self-checking bench for sm_addsub_pipe: directed vector table, saturation and
// backpressure sequences, and randomized traffic against an integer reference model.
module tb_sm_addsub_pipe;

    localparam int     WIDTH  = 18;
    localparam int     ACC_W  = 24;
    localparam longint MAXMAG = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [WIDTH-1:0]  in_p;
    logic [WIDTH-1:0]  in_q;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_res;
    logic              out_ovf;
    logic [1:0]        out_op;

    sm_addsub_pipe #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_p      (in_p),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_ovf   (out_ovf),
        .out_op    (out_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [23:0] res;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [17:0] p;
        logic [17:0] q;
        logic [23:0] res;
        logic        ovf;
    } vec_t;

    int     checks;
    int     errors;
    int     n_deliv;
    longint model_acc;
    exp_t   exp_q[$];
    exp_t   got_q[$];
    vec_t   vt[10];
    logic   acc_b;
    logic   rdy_b;
    logic   rdy_v;
    logic [23:0] held_res;
    int     issued;
    int     hold;
    int     n_acc;

    function automatic longint sm_val(input logic [17:0] v);
        longint m;
        m = longint'(v[16:0]);
        return v[17] ? -m : m;
    endfunction

    function automatic exp_t model(input logic [1:0] op, input logic [17:0] p, input logic [17:0] q);
        exp_t   e;
        longint r;
        case (op)
            2'b00:   r = sm_val(p) + sm_val(q);
            2'b01:   r = sm_val(p) - sm_val(q);
            2'b10:   r = model_acc + sm_val(p);
            default: r = sm_val(p);
        endcase
        e.ovf = 1'b0;
        if (r > MAXMAG) begin
            r = MAXMAG;
            e.ovf = 1'b1;
        end else if (r < -MAXMAG) begin
            r = -MAXMAG;
            e.ovf = 1'b1;
        end
        if (op[1]) model_acc = r;
        e.op  = op;
        e.res = (r < 0) ? {1'b1, 23'(-r)} : {1'b0, 23'(r)};
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check delivery and log acceptance, end at next negedge.
    task automatic step(input logic v, input logic [1:0] op, input logic [17:0] p,
                        input logic [17:0] q, input logic rdy,
                        output logic accepted, output logic irdy);
        exp_t e;
        in_valid  = v;
        in_op     = op;
        in_p      = p;
        in_q      = q;
        out_ready = rdy;
        #1;
        if (out_valid && out_ready) begin
            n_deliv++;
            got_q.push_back('{out_op, out_res, out_ovf});
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got op=%b res=%h ovf=%b with nothing pending",
                         out_op, out_res, out_ovf);
            end else begin
                e = exp_q.pop_front();
                if ({out_op, out_res, out_ovf} !== {e.op, e.res, e.ovf}) begin
                    errors++;
                    $display("FAIL stream_result: got op=%b res=%h ovf=%b expected op=%b res=%h ovf=%b",
                             out_op, out_res, out_ovf, e.op, e.res, e.ovf);
                end
            end
        end
        irdy     = in_ready;
        accepted = in_valid && in_ready;
        if (accepted) exp_q.push_back(model(op, p, q));
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            step(1'b0, 2'b00, 18'h0, 18'h0, 1'b1, acc_b, rdy_b);
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'b10;
        in_p      = 18'h00005;
        in_q      = 18'h0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        model_acc = 0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_res",   64'(out_res),   64'd0);
        chk("rst_out_ovf",   64'(out_ovf),   64'd0);
        chk("rst_out_op",    64'(out_op),    64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
    endtask

    // Isolated beat: checks the three-edge latency and the result fields.
    task automatic single_op(input vec_t v, input int idx);
        in_valid  = 1'b1;
        in_op     = v.op;
        in_p      = v.p;
        in_q      = v.q;
        out_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d_in_ready", idx), 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk($sformatf("vec%0d_lat1", idx), 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        chk($sformatf("vec%0d_lat2", idx), 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        chk($sformatf("vec%0d_valid", idx), 64'(out_valid), 64'd1);
        chk($sformatf("vec%0d_res", idx),   64'(out_res),   64'(v.res));
        chk($sformatf("vec%0d_ovf", idx),   64'(out_ovf),   64'(v.ovf));
        chk($sformatf("vec%0d_op", idx),    64'(out_op),    64'(v.op));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; n_deliv = 0; model_acc = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_p = '0; in_q = '0; out_ready = 1'b1;

        vt[0] = '{2'b00, 18'h00005, 18'h20003, 24'h000002, 1'b0};
        vt[1] = '{2'b01, 18'h3FFFF, 18'h1FFFF, 24'h83FFFE, 1'b0};
        vt[2] = '{2'b00, 18'h00007, 18'h20007, 24'h000000, 1'b0};
        vt[3] = '{2'b00, 18'h20000, 18'h00000, 24'h000000, 1'b0};
        vt[4] = '{2'b01, 18'h20000, 18'h20000, 24'h000000, 1'b0};
        vt[5] = '{2'b11, 18'h00064, 18'h3FFFF, 24'h000064, 1'b0};
        vt[6] = '{2'b10, 18'h20070, 18'h12345, 24'h80000C, 1'b0};
        vt[7] = '{2'b01, 18'h00003, 18'h00005, 24'h800002, 1'b0};
        vt[8] = '{2'b11, 18'h20000, 18'h00000, 24'h000000, 1'b0};
        vt[9] = '{2'b10, 18'h1FFFF, 18'h00000, 24'h01FFFF, 1'b0};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) single_op(vt[i], i);

        // Saturation: LOAD +100, 64 x ACC +131071, then ACC -1.
        got_q.delete();
        n_acc = 0;
        step(1'b1, 2'b11, 18'h00064, 18'h0, 1'b1, acc_b, rdy_b);
        if (acc_b) n_acc++;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 2'b10, 18'h1FFFF, 18'h0, 1'b1, acc_b, rdy_b);
            if (acc_b) n_acc++;
        end
        step(1'b1, 2'b10, 18'h20001, 18'h0, 1'b1, acc_b, rdy_b);
        if (acc_b) n_acc++;
        drain();
        chk("sat_accepted", 64'(n_acc), 64'd66);
        chk("sat_count", 64'(got_q.size()), 64'd66);
        chk("sat_63_res", 64'(got_q[63].res), 64'h7E0025);
        chk("sat_63_ovf", 64'(got_q[63].ovf), 64'd0);
        chk("sat_64_res", 64'(got_q[64].res), 64'h7FFFFF);
        chk("sat_64_ovf", 64'(got_q[64].ovf), 64'd1);
        chk("sat_65_res", 64'(got_q[65].res), 64'h7FFFFE);
        chk("sat_65_ovf", 64'(got_q[65].ovf), 64'd0);

        // Backpressure: 5 ADDs, out_ready held low 4 cycles from the first out_valid.
        n_deliv = 0; issued = 0; hold = 0;
        for (int cyc = 0; cyc < 40 && (issued < 5 || exp_q.size() > 0); cyc++) begin
            if (out_valid && hold < 4) begin
                if (hold == 0) held_res = out_res;
                else chk("bp_res_stable", 64'(out_res), 64'(held_res));
                rdy_v = 1'b0;
                hold++;
            end else begin
                rdy_v = 1'b1;
            end
            step(issued < 5, 2'b00, 18'(issued + 1), 18'(issued * 16), rdy_v, acc_b, rdy_b);
            if (!rdy_v) chk("bp_in_ready_low", 64'(rdy_b), 64'd0);
            if (acc_b) issued++;
        end
        chk("bp_delivered", 64'(n_deliv), 64'd5);
        chk("bp_pending", 64'(exp_q.size()), 64'd0);

        // Bubbles: alternating valid, ACC +1 per beat, random out_ready.
        got_q.delete();
        n_acc = 0;
        step(1'b1, 2'b11, 18'h00000, 18'h0, 1'b1, acc_b, rdy_b);
        for (int cyc = 0; cyc < 120; cyc++) begin
            step((cyc % 2) == 0, 2'b10, 18'h00001, 18'h0, 1'($urandom_range(0, 1)), acc_b, rdy_b);
            if (acc_b) n_acc++;
        end
        drain();
        chk("bubble_final", 64'(got_q[got_q.size() - 1].res), 64'(n_acc));

        // Random ops, valid and ready.
        for (int cyc = 0; cyc < 400; cyc++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 18'($urandom),
                 18'($urandom), 1'($urandom_range(0, 3) != 0), acc_b, rdy_b);
        end
        drain();

        // Reset with three beats in flight and the output stalled.
        step(1'b1, 2'b10, 18'h00123, 18'h0, 1'b1, acc_b, rdy_b);
        step(1'b1, 2'b00, 18'h00011, 18'h00022, 1'b1, acc_b, rdy_b);
        step(1'b1, 2'b01, 18'h00044, 18'h00001, 1'b1, acc_b, rdy_b);
        do_reset();
        got_q.delete();
        step(1'b1, 2'b10, 18'h00005, 18'h0, 1'b1, acc_b, rdy_b);
        drain();
        chk("post_rst_count", 64'(got_q.size()), 64'd1);
        chk("post_rst_res", 64'(got_q[0].res), 64'h000005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
